// File: rtl/gpio_input_pkg.sv
// Shared types and default constants for the GPIO input debounce block.
package gpio_input_pkg;

   typedef enum logic [1:0] {
      LOW,
      CHK_HI,
      HIGH,
      CHK_LO
   } deb_state_e;

   localparam int unsigned DEB_SYNC_STAGES = 2;
   localparam int unsigned DEB_CYCLES_10MS = 125000;

endpackage

// File: rtl/gpio_debounce_chan.sv
// One input channel: synchroniser, stable-count debounce FSM, edge pulses
// and a sticky change flag with write-1-to-clear.
module gpio_debounce_chan
   import gpio_input_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEB_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_10MS,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   input  logic clr_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic changed_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   deb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   changed_q, changed_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         state_q   <= LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         LOW: begin
            if (s) begin
               state_d = CHK_HI;
               cnt_d   = '0;
            end
         end
         CHK_HI: begin
            if (!s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_d = CHK_LO;
               cnt_d   = '0;
            end
         end
         CHK_LO: begin
            if (s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered pulses feed the flag, so a set always beats a same-cycle clear.
   assign changed_d = (changed_q & ~clr_i) | rise_q | fall_q;

   assign level_o   = level_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/gpio_input_debounce.sv
// Debounced GPIO input bank: one independent channel per bit plus a
// level interrupt from the enabled sticky change flags.
module gpio_input_debounce
   import gpio_input_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = DEB_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_10MS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_raw,
   input  logic [WIDTH-1:0] i_irq_en,
   input  logic [WIDTH-1:0] i_clr_changed,
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic [WIDTH-1:0] o_changed,
   output logic             o_irq
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      gpio_debounce_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (i_raw[g]),
         .clr_i     (i_clr_changed[g]),
         .level_o   (o_level[g]),
         .rise_o    (o_rise[g]),
         .fall_o    (o_fall[g]),
         .changed_o (o_changed[g])
      );
   end

   assign o_irq = |(o_changed & i_irq_en);

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Self-checking bench: hand vectors, corner sequences and randomised input
// against a run-length reference model.
module tb_gpio_input_debounce;

   localparam int W = 8;
   localparam int S = 2;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] raw_r, en_r, clr_r;
   logic [W-1:0] lvl, rise, fall, chg;
   logic         irq;

   int total = 0;
   int bad   = 0;

   gpio_input_debounce #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_raw         (raw_r),
      .i_irq_en      (en_r),
      .i_clr_changed (clr_r),
      .o_level       (lvl),
      .o_rise        (rise),
      .o_fall        (fall),
      .o_changed     (chg),
      .o_irq         (irq)
   );

   always #5 clk = ~clk;

   // Reference model: input delay line, run length of the delayed input,
   // accept when it differs from the level and has held for D+1 samples.
   logic [W-1:0] m_hist [S];
   logic [W-1:0] m_last_s, m_level, m_rise, m_fall, m_chg;
   int           m_run [W];

   task automatic model_reset();
      for (int j = 0; j < S; j++) m_hist[j] = '0;
      for (int i = 0; i < W; i++) m_run[i] = D + 1;
      m_last_s = '0;
      m_level  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_chg    = '0;
   endtask

   task automatic model_step(input logic [W-1:0] raw, input logic [W-1:0] clr);
      logic [W-1:0] s;
      s     = m_hist[S-1];
      m_chg = (m_chg & ~clr) | m_rise | m_fall;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] == m_last_s[i]) begin
            if (m_run[i] < 1000) m_run[i]++;
         end else begin
            m_run[i] = 1;
         end
         if (s[i] != m_level[i] && m_run[i] >= D + 1) begin
            m_level[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
         end
      end
      m_last_s = s;
      for (int j = S - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = raw;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      model_step(raw_r, clr_r);
      @(posedge clk);
      #1;
      chk("m_level",   32'(lvl),  32'(m_level));
      chk("m_rise",    32'(rise), 32'(m_rise));
      chk("m_fall",    32'(fall), 32'(m_fall));
      chk("m_changed", 32'(chg),  32'(m_chg));
      chk("m_irq",     32'(irq),  32'(|(m_chg & en_r)));
   endtask

   typedef struct {
      logic [W-1:0] raw, en, clr, lvl, rise, fall, chg;
      logic         irq;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int pulses, lvl_seen;
      bit found;

      for (int k = 0; k < 6; k++)
         tbl[k] = '{raw: 8'h01, en: 8'h01, clr: 8'h00, lvl: 8'h00, rise: 8'h00,
                    fall: 8'h00, chg: 8'h00, irq: 1'b0};
      tbl[6] = '{raw: 8'h01, en: 8'h01, clr: 8'h00, lvl: 8'h01, rise: 8'h01,
                 fall: 8'h00, chg: 8'h00, irq: 1'b0};
      tbl[7] = '{raw: 8'h01, en: 8'h01, clr: 8'h00, lvl: 8'h01, rise: 8'h00,
                 fall: 8'h00, chg: 8'h01, irq: 1'b1};
      tbl[8] = '{raw: 8'h01, en: 8'h01, clr: 8'h01, lvl: 8'h01, rise: 8'h00,
                 fall: 8'h00, chg: 8'h00, irq: 1'b0};
      tbl[9] = '{raw: 8'h01, en: 8'h01, clr: 8'h00, lvl: 8'h01, rise: 8'h00,
                 fall: 8'h00, chg: 8'h00, irq: 1'b0};

      rst   = 1'b1;
      raw_r = '0;
      en_r  = '0;
      clr_r = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {lvl, rise, fall, chg, 7'd0, irq}, 32'd0);
      rst = 1'b0;
      repeat (3) cyc();

      // Clean rise on bit 0: first sampled at table step 0, accepted at step 6.
      for (int k = 0; k < 10; k++) begin
         raw_r = tbl[k].raw;
         en_r  = tbl[k].en;
         clr_r = tbl[k].clr;
         cyc();
         chk($sformatf("tbl%0d_level", k),   32'(lvl),  32'(tbl[k].lvl));
         chk($sformatf("tbl%0d_rise", k),    32'(rise), 32'(tbl[k].rise));
         chk($sformatf("tbl%0d_fall", k),    32'(fall), 32'(tbl[k].fall));
         chk($sformatf("tbl%0d_changed", k), 32'(chg),  32'(tbl[k].chg));
         chk($sformatf("tbl%0d_irq", k),     32'(irq),  32'(tbl[k].irq));
      end
      clr_r = '0;

      // Bounce on bit 1: pulses of 2 cycles are rejected.
      pulses   = 0;
      lvl_seen = 0;
      for (int k = 0; k < 16; k++) begin
         raw_r[1] = (k < 8) ? ~k[1] : 1'b0;
         cyc();
         pulses   += int'(rise[1]) + int'(fall[1]);
         lvl_seen += int'(lvl[1]);
      end
      chk("bounce_pulses", 32'(pulses), 32'd0);
      chk("bounce_level",  32'(lvl_seen), 32'd0);
      pulses = 0;
      raw_r[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         pulses += int'(rise[1]);
      end
      chk("bounce_then_hold_rise", 32'(pulses), 32'd1);

      // Fall on bit 2 with interrupt enabled.
      raw_r[2] = 1'b1;
      repeat (10) cyc();
      clr_r = 8'h04;
      cyc();
      clr_r = '0;
      en_r  = 8'h04;
      raw_r[2] = 1'b0;
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         cyc();
         found = fall[2];
      end
      chk("fall2_seen", 32'(found), 32'd1);
      chk("fall2_irq_before", {lvl[2], chg[2], irq}, 32'b000);
      cyc();
      chk("fall2_irq_after", {chg[2], irq}, 32'b11);
      clr_r = 8'h04;
      cyc();
      clr_r = '0;
      chk("fall2_cleared", {chg[2], irq}, 32'b00);

      // Set/clear collision on bit 3.
      raw_r[3] = 1'b1;
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         cyc();
         found = rise[3];
      end
      chk("rise3_seen", 32'(found), 32'd1);
      clr_r = 8'h08;
      cyc();
      chk("collision_set_wins", 32'(chg[3]), 32'd1);
      cyc();
      clr_r = '0;
      chk("collision_later_clear", 32'(chg[3]), 32'd0);

      // Reset two cycles into CHK_HI on bit 4.
      raw_r[4] = 1'b1;
      repeat (4) cyc();
      #3 rst = 1'b1;
      #1;
      chk("async_reset_outputs", {lvl, rise, fall, chg, 7'd0, irq}, 32'd0);
      model_reset();
      raw_r = 8'hFF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // First sampling edge is the first after release; accept S+D edges later.
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk($sformatf("post_reset_rise_e%0d", k), 32'(rise), (k == 1 + S + D) ? 32'hFF : 32'h00);
      end

      // Parallel events 8'h00 -> 8'hA5.
      raw_r = 8'h00;
      repeat (12) cyc();
      clr_r = 8'hFF;
      cyc();
      clr_r = '0;
      raw_r = 8'hA5;
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         cyc();
         found = (rise != 0);
      end
      chk("parallel_rise", 32'(rise), 32'hA5);
      cyc();
      chk("parallel_changed", 32'(chg), 32'hA5);

      // Randomised stimulus against the model.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 5) == 0) raw_r[i] = ~raw_r[i];
         en_r  = W'($urandom);
         clr_r = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
